// File: rtl/elastic_pkg.sv
// Width helpers shared by the elastic buffering stages.
package elastic_pkg;

    // Ring pointer width; kept at least one bit so tiny rings still elaborate.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/elastic_ring.sv
// DEPTH x DW circular storage with head/tail pointers and a separate occupancy count.
module elastic_ring
    import elastic_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = ptr_w(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (i_push) begin
                mem_q[tail_q] <= i_data;
                tail_q        <= tail_q + 1'b1;
            end
            if (i_pop)
                head_q <= head_q + 1'b1;
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_data  = mem_q[head_q];
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/elastic_buf.sv
// Elastic buffer: DEPTH-entry ring plus a registered output stage, all handshakes registered.
// ELASTIC_BUF_BYPASS_EN lets a beat arriving at an idle, empty buffer skip the ring.
module elastic_buf
    import elastic_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int LW   = lvl_w(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [LW-1:0] o_level
);

    logic          o_valid_q, o_valid_d;
    logic [DW-1:0] o_data_q, o_data_d;
    logic [DW-1:0] ring_data;
    logic          ring_full, ring_empty;
    logic [CW-1:0] ring_count;
    logic          accept, advance, bypass, push, pop;

    // o_ready depends only on ring occupancy, never on i_ready.
    assign o_ready = !ring_full;
    assign accept  = i_valid & o_ready;
    assign advance = !o_valid_q | i_ready;
    assign pop     = advance & !ring_empty;

`ifdef ELASTIC_BUF_BYPASS_EN
    assign bypass  = advance & accept & ring_empty;
`else
    assign bypass  = 1'b0;
`endif

    assign push = accept & !bypass;

    elastic_ring #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (i_data),
        .i_pop   (pop),
        .o_data  (ring_data),
        .o_full  (ring_full),
        .o_empty (ring_empty),
        .o_count (ring_count)
    );

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        if (advance) begin
            if (!ring_empty) begin
                o_valid_d = 1'b1;
                o_data_d  = ring_data;
            end else if (bypass) begin
                o_valid_d = 1'b1;
                o_data_d  = i_data;
            end else begin
                o_valid_d = 1'b0;
                o_data_d  = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_level = LW'(ring_count) + LW'(o_valid_q);

endmodule

// File: tb/tb_elastic_buf.sv
// Directed and randomized checks of elastic_buf (DW=8, DEPTH=4); handles either bypass build.
module tb_elastic_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 2);
`ifdef ELASTIC_BUF_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic [LW-1:0] o_level;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    elastic_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_level (o_level)
    );

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_valid = 1'b1; i_data = 8'h77; i_ready = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", o_data); end
        checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", o_level); end
        tick();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_after got=%b exp=0", o_valid); end
    endtask

    task automatic test_latency();
        int n;
        i_valid = 1'b1; i_data = 8'hA5; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (o_valid !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        checks++; if (n != LAT) begin errors++; $display("FAIL latency got=%0d exp=%0d", n, LAT); end
        checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL latency_data got=%h exp=a5", o_data); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_level !== 3'd0) begin
            errors++; $display("FAIL latency_empty got valid=%b level=%0d exp valid=0 level=0", o_valid, o_level);
        end
    endtask

    task automatic test_fill();
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=1", k, o_ready); end
            i_valid = 1'b1; i_data = DW'(k);
            tick();
        end
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", o_ready); end
        checks++; if (o_level !== 3'd5) begin errors++; $display("FAIL fill_level got=%0d exp=5", o_level); end
        repeat (2) begin
            checks++; if (o_valid !== 1'b1 || o_data !== 8'h01) begin
                errors++; $display("FAIL fill_head got valid=%b data=%h exp valid=1 data=01", o_valid, o_data);
            end
            tick();
        end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_hold_ready got=%b exp=0", o_ready); end
    endtask

    task automatic test_drain();
        i_ready = 1'b1; i_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++; if (o_valid !== 1'b1 || o_data !== DW'(k)) begin
                errors++; $display("FAIL drain_beat_%0d got valid=%b data=%h exp valid=1 data=%h", k, o_valid, o_data, DW'(k));
            end
            tick();
        end
        checks++; if (o_valid !== 1'b0 || o_level !== 3'd0) begin
            errors++; $display("FAIL drain_empty got valid=%b level=%0d exp valid=0 level=0", o_valid, o_level);
        end
    endtask

    task automatic test_streaming();
        int  exp_d = 0;
        bit  started = 0;
        i_ready = 1'b1;
        for (int c = 0; c < 68; c++) begin
            i_valid = (c < 64);
            i_data  = DW'(c);
            tick();
            if (o_valid === 1'b1) begin
                started = 1;
                checks++; if (o_data !== DW'(exp_d)) begin errors++; $display("FAIL stream_data got=%h exp=%h", o_data, DW'(exp_d)); end
                exp_d++;
            end else if (started && c < 63) begin
                checks++; errors++; $display("FAIL stream_gap cycle=%0d got valid=0 exp valid=1", c);
            end
            checks++; if (o_level > 3'd2) begin errors++; $display("FAIL stream_level got=%0d exp<=2", o_level); end
        end
        i_valid = 1'b0;
        tick();
        checks++; if (exp_d != 64) begin errors++; $display("FAIL stream_count got=%0d exp=64", exp_d); end
        checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL stream_empty got=%0d exp=0", o_level); end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        bit            stalled = 0;
        bit            just_rst = 0;
        logic [DW-1:0] prev_d = '0;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            if (just_rst) begin
                checks++; if (o_valid !== 1'b0 || o_level !== 3'd0) begin
                    errors++; $display("FAIL rand_reset got valid=%b level=%0d exp 0/0", o_valid, o_level);
                end
            end
            checks++; if (o_level !== LW'(q.size())) begin
                errors++; $display("FAIL rand_level cycle=%0d got=%0d exp=%0d", c, o_level, q.size());
            end
            checks++; if (o_ready !== (q.size() != DEPTH + 1)) begin
                errors++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, o_ready, q.size() != DEPTH + 1);
            end
            if (stalled) begin
                checks++; if (o_valid !== 1'b1 || o_data !== prev_d) begin
                    errors++; $display("FAIL rand_stable cycle=%0d got valid=%b data=%h exp valid=1 data=%h", c, o_valid, o_data, prev_d);
                end
            end
            i_reset = (c == 5000);
            i_valid = 1'($urandom_range(0, 1));
            i_data  = DW'($urandom);
            i_ready = 1'($urandom_range(0, 1));
            if (i_reset) begin
                q.delete();
            end else begin
                if (o_valid === 1'b1 && i_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL rand_dup cycle=%0d got data=%h exp no beat", c, o_data);
                    end else begin
                        if (o_data !== q[0]) begin
                            errors++; $display("FAIL rand_order cycle=%0d got=%h exp=%h", c, o_data, q[0]);
                        end
                        void'(q.pop_front());
                    end
                end
                if (i_valid && o_ready === 1'b1) q.push_back(i_data);
            end
            just_rst = i_reset;
            stalled  = !i_reset && o_valid === 1'b1 && !i_ready;
            prev_d   = o_data;
            tick();
        end
        i_reset = 1'b0; i_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_drain();
        test_streaming();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
